water_level_reader: RTL and testbench

// - Input-side reader for the irrigation controller's water-tank probes.
// - Synchronises and debounces raw probes h/m/l, then validates the

---
 rtl/water_level_reader.sv | 191 +++++++++++++++++++
 tb/tb_water_level_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/water_level_reader.sv
`default_nettype none
// ============================================================================
// Module      : water_level_reader
// Description : Input-side reader for the irrigation controller's water-tank
//               probes. Synchronises and debounces the raw high/medium/low
//               probes, validates the probe combination, encodes the tank
//               level and flags impossible combinations as a fault.
// Ports       : clk        - system clock, all state on rising edge
//               rst_n      - asynchronous active-low reset
//               i_h_raw    - raw high probe (1 = water present), async/bouncy
//               i_m_raw    - raw medium probe
//               i_l_raw    - raw low probe
//               o_h/o_m/o_l- debounced probe values (registered)
//               o_level    - 0 empty, 1 low, 2 medium, 3 high; frozen in fault
//               o_fault    - probe combination invalid
//               o_changed  - one-clock pulse after level or fault changes
// Revision    : 1.0 - initial release
// ============================================================================
module water_level_reader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FAULT_CYCLES    = 3,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_h_raw,
  input  logic       i_m_raw,
  input  logic       i_l_raw,
  output logic       o_h,
  output logic       o_m,
  output logic       o_l,
  output logic [1:0] o_level,
  output logic       o_fault,
  output logic       o_changed
);

  localparam int              FC_W        = $clog2(FAULT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0]  C_FLT_CNT  = FC_W'(FAULT_CYCLES);

  localparam logic [2:0] S_EMPTY = 3'd0;
  localparam logic [2:0] S_LOW   = 3'd1;
  localparam logic [2:0] S_MED   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  // Channel order throughout: bit 2 = high, bit 1 = medium, bit 0 = low.
  logic [2:0]       w_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_stable;
  logic [2:0]       r_hml;
  logic [CNT_W-1:0] r_cnt [3];

  assign w_raw = {i_h_raw, i_m_raw, i_l_raw};

  // --------------------------------------------------------------------------
  // Two-flop synchronisers and per-channel debounce. A channel is accepted
  // only after its synced value has differed from the stable value for
  // DEBOUNCE_CYCLES consecutive clocks; any agreeing clock restarts the count.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_hml    <= '0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_hml   <= r_stable;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == C_DB_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Combination decode: only the "filled from the bottom" patterns are legal.
  // --------------------------------------------------------------------------
  logic       w_valid;
  logic [1:0] w_lvl;

  always_comb begin
    w_valid = 1'b0;
    w_lvl   = 2'd0;
    case (r_stable)
      3'b000: begin w_valid = 1'b1; w_lvl = 2'd0; end
      3'b001: begin w_valid = 1'b1; w_lvl = 2'd1; end
      3'b011: begin w_valid = 1'b1; w_lvl = 2'd2; end
      3'b111: begin w_valid = 1'b1; w_lvl = 2'd3; end
      default: begin w_valid = 1'b0; w_lvl = 2'd0; end
    endcase
  end

  // --------------------------------------------------------------------------
  // Level / fault state machine. It works on the stable bits so a valid level
  // lands on o_level in the same clock the new bits reach o_h/o_m/o_l. The
  // persistence counters run to FAULT_CYCLES before switching, i.e. a combo
  // must have been visible on the probe outputs for FAULT_CYCLES full clocks
  // before the fault flag enters or leaves.
  // --------------------------------------------------------------------------
  logic [2:0]      r_state;
  logic [1:0]      r_level;
  logic            r_fault;
  logic [FC_W-1:0] r_bad_cnt;
  logic [FC_W-1:0] r_good_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_level    <= 2'd0;
      r_fault    <= 1'b0;
      r_bad_cnt  <= '0;
      r_good_cnt <= '0;
    end else if (r_state != S_FAULT) begin
      r_good_cnt <= '0;
      if (w_valid) begin
        r_state   <= {1'b0, w_lvl};
        r_level   <= w_lvl;
        r_bad_cnt <= '0;
      end else if (r_bad_cnt == C_FLT_CNT) begin
        r_state   <= S_FAULT;
        r_fault   <= 1'b1;
        r_bad_cnt <= '0;
      end else begin
        r_bad_cnt <= r_bad_cnt + 1'b1;
      end
    end else begin
      r_bad_cnt <= '0;
      if (w_valid) begin
        if (r_good_cnt == C_FLT_CNT) begin
          r_state    <= {1'b0, w_lvl};
          r_level    <= w_lvl;
          r_fault    <= 1'b0;
          r_good_cnt <= '0;
        end else begin
          r_good_cnt <= r_good_cnt + 1'b1;
        end
      end else begin
        r_good_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Change pulse: compare against one-clock-delayed copies, so the pulse
  // follows the update by one clock and a simultaneous level+fault update
  // still gives a single pulse.
  // --------------------------------------------------------------------------
  logic [1:0] r_level_q;
  logic       r_fault_q;
  logic       r_changed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= 2'd0;
      r_fault_q <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_level_q <= r_level;
      r_fault_q <= r_fault;
      r_changed <= (r_level != r_level_q) || (r_fault != r_fault_q);
    end
  end

  assign o_h       = r_hml[2];
  assign o_m       = r_hml[1];
  assign o_l       = r_hml[0];
  assign o_level   = r_level;
  assign o_fault   = r_fault;
  assign o_changed = r_changed;

  // S_LOW/S_MED/S_HIGH are reached through {1'b0, w_lvl}; keep them named.
  logic w_unused;
  assign w_unused = ^{S_LOW, S_MED, S_HIGH};

endmodule
`default_nettype wire

// File: tb/tb_water_level_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_water_level_reader
// Description : Self-checking bench for water_level_reader (DEBOUNCE_CYCLES=4,
//               FAULT_CYCLES=3): settled-state vector table plus directed
//               timing sequences for debounce, climb, fault, transient and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_water_level_reader;

  logic       clk;
  logic       rst_n;
  logic       h_raw, m_raw, l_raw;
  logic       h, m, l;
  logic [1:0] level;
  logic       fault;
  logic       changed;

  int n_tests = 0;
  int n_fail  = 0;

  water_level_reader #(
    .DEBOUNCE_CYCLES(4),
    .FAULT_CYCLES   (3),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_h_raw  (h_raw),
    .i_m_raw  (m_raw),
    .i_l_raw  (l_raw),
    .o_h      (h),
    .o_m      (m),
    .o_l      (l),
    .o_level  (level),
    .o_fault  (fault),
    .o_changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] raw;
    int         hold;
    logic [2:0] hml;
    logic [1:0] lvl;
    logic       flt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    {h_raw, m_raw, l_raw} = v;
  endtask

  // Wait n rising edges, then settle on the following falling edge.
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  int pulses;
  int fault_seen;
  int l_seen;

  // Observe n cycles, accumulating changed pulses and fault / l activity.
  task automatic observe(input int n);
    for (int k = 0; k < n; k++) begin
      clocks(1);
      if (changed) pulses++;
      if (fault)   fault_seen++;
      if (l)       l_seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'b000, 20, 3'b000, 2'd0, 1'b0};
    tbl[1] = '{3'b001, 20, 3'b001, 2'd1, 1'b0};
    tbl[2] = '{3'b011, 20, 3'b011, 2'd2, 1'b0};
    tbl[3] = '{3'b111, 20, 3'b111, 2'd3, 1'b0};
    tbl[4] = '{3'b101, 20, 3'b101, 2'd3, 1'b1};
    tbl[5] = '{3'b111, 20, 3'b111, 2'd3, 1'b0};
    tbl[6] = '{3'b010, 20, 3'b010, 2'd3, 1'b1};
    tbl[7] = '{3'b000, 20, 3'b000, 2'd0, 1'b0};
    tbl[8] = '{3'b110, 20, 3'b110, 2'd0, 1'b1};
    tbl[9] = '{3'b011, 20, 3'b011, 2'd2, 1'b0};

    // ---------------- reset with raw = 111 ----------------
    rst_n = 1'b1;
    drive(3'b111);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_hml",     int'({h, m, l}), 0);
    chk("rst_level",   int'(level), 0);
    chk("rst_fault",   int'(fault), 0);
    chk("rst_changed", int'(changed), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clocks(6);
    chk("rel_level_6", int'(level), 0);
    clocks(1);
    chk("rel_level_7", int'(level), 3);
    chk("rel_hml_7",   int'({h, m, l}), 7);

    // ---------------- settled-state table ----------------
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].raw);
      clocks(tbl[i].hold);
      chk($sformatf("tbl%0d_hml", i),   int'({h, m, l}), int'(tbl[i].hml));
      chk($sformatf("tbl%0d_level", i), int'(level), int'(tbl[i].lvl));
      chk($sformatf("tbl%0d_fault", i), int'(fault), int'(tbl[i].flt));
    end

    // ---------------- debounce latency ----------------
    drive(3'b000);
    clocks(20);
    drive(3'b001);
    clocks(6);
    chk("db_l_6",     int'(l), 0);
    chk("db_level_6", int'(level), 0);
    clocks(1);
    chk("db_l_7",       int'(l), 1);
    chk("db_level_7",   int'(level), 1);
    chk("db_changed_7", int'(changed), 0);
    clocks(1);
    chk("db_changed_8", int'(changed), 1);
    clocks(1);
    chk("db_changed_9", int'(changed), 0);

    // ---------------- 3-clock glitch is discarded ----------------
    drive(3'b000);
    clocks(20);
    drive(3'b001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(3'b000);
    pulses = 0; fault_seen = 0; l_seen = 0;
    observe(20);
    chk("glitch_l_seen", l_seen, 0);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_level",  int'(level), 0);

    // ---------------- climb 001 -> 011 -> 111 ----------------
    pulses = 0; fault_seen = 0; l_seen = 0;
    drive(3'b001); observe(20);
    chk("climb_level1", int'(level), 1);
    drive(3'b011); observe(20);
    chk("climb_level2", int'(level), 2);
    drive(3'b111); observe(20);
    chk("climb_level3", int'(level), 3);
    chk("climb_pulses", pulses, 3);
    chk("climb_fault",  fault_seen, 0);

    // ---------------- fault entry / exit timing ----------------
    drive(3'b011);
    clocks(20);
    chk("flt_start_level", int'(level), 2);
    drive(3'b101);
    clocks(9);
    chk("flt_in_9",   int'(fault), 0);
    clocks(1);
    chk("flt_in_10",  int'(fault), 1);
    chk("flt_level",  int'(level), 2);
    clocks(2);
    chk("flt_chg_pulse", int'(changed), 0);
    drive(3'b111);
    clocks(9);
    chk("flt_out_9",       int'(fault), 1);
    chk("flt_out_9_level", int'(level), 2);
    clocks(1);
    chk("flt_out_10",       int'(fault), 0);
    chk("flt_out_10_level", int'(level), 3);
    clocks(1);
    chk("flt_out_changed", int'(changed), 1);

    // ---------------- transient 101 for 2 clocks ----------------
    drive(3'b001);
    clocks(20);
    chk("tr_start_level", int'(level), 1);
    pulses = 0; fault_seen = 0;
    drive(3'b101);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(3'b111);
    observe(20);
    chk("tr_fault_seen", fault_seen, 0);
    chk("tr_level",      int'(level), 3);
    chk("tr_pulses",     pulses, 1);

    // ---------------- asynchronous reset mid-fault ----------------
    drive(3'b101);
    clocks(20);
    chk("ar_pre_fault", int'(fault), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_fault",   int'(fault), 0);
    chk("ar_level",   int'(level), 0);
    chk("ar_hml",     int'({h, m, l}), 0);
    chk("ar_changed", int'(changed), 0);
    @(negedge clk);
    drive(3'b111);
    rst_n = 1'b1;
    clocks(7);
    chk("ar_rel_level", int'(level), 3);
    chk("ar_rel_fault", int'(fault), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
